// File: rtl/muxf_pkg.sv
// ============================================================================
// muxf_pkg : shared types and fault-application helper for muxf_tree_fi
// Revision : 1.0
// ============================================================================
`default_nettype none

package muxf_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'b00,
    FORCE = 2'b01,
    FLIP  = 2'b10,
    RSVD  = 2'b11
  } fi_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    TIMED  = 2'b01,
    STICKY = 2'b10
  } fi_state_t;

  // Per-bit so it composes over any data width; CLEAR and RSVD pass data through.
  function automatic logic fault_apply(input logic m, input logic mask,
                                       input logic value, input fi_mode_t mode);
    logic r;
    case (mode)
      FORCE:   r = mask ? value : m;
      FLIP:    r = m ^ mask;
      default: r = m;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/muxf_fi_ctrl.sv
// ============================================================================
// muxf_fi_ctrl : fault-injection FSM, duration counter, config and handshake
// Revision : 1.0
// ============================================================================
`default_nettype none

module muxf_fi_ctrl
  import muxf_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic             fi_valid_i,
  output logic             fi_ready_o,
  input  fi_mode_t         fi_mode_i,
  input  logic [WIDTH-1:0] fi_mask_i,
  input  logic [WIDTH-1:0] fi_value_i,
  input  logic [CNT_W-1:0] fi_cycles_i,
  output logic             fi_active_o,
  output fi_mode_t         app_mode_o,
  output logic [WIDTH-1:0] app_mask_o,
  output logic [WIDTH-1:0] app_value_o
);

  fi_state_t        state_q, state_d;
  fi_mode_t         mode_q,  mode_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] mask_q,  mask_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             accept;
  logic             is_fault_cmd;

  assign fi_ready_o   = (state_q != TIMED);
  assign fi_active_o  = (state_q != IDLE);
  assign accept       = fi_valid_i & fi_ready_o;
  assign is_fault_cmd = (fi_mode_i == FORCE) || (fi_mode_i == FLIP);

  // The capture stage sees the registered configuration, so an accepted
  // command only affects O from the following edge onward.
  assign app_mode_o  = (state_q == IDLE) ? CLEAR : mode_q;
  assign app_mask_o  = mask_q;
  assign app_value_o = value_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    value_d = value_q;
    case (state_q)
      TIMED: begin
        if (ce_i) begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_d = IDLE;
          end
        end
      end
      IDLE, STICKY: begin
        if (accept) begin
          if (is_fault_cmd) begin
            mode_d  = fi_mode_i;
            mask_d  = fi_mask_i;
            value_d = fi_value_i;
            cnt_d   = fi_cycles_i;
            state_d = (fi_cycles_i == '0) ? STICKY : TIMED;
          end else begin
            state_d = IDLE;
            mode_d  = CLEAR;
            mask_d  = '0;
            value_d = '0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mode_q  <= CLEAR;
      cnt_q   <= '0;
      mask_q  <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      value_q <= value_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/muxf_tree_fi.sv
// ============================================================================
// muxf_tree_fi : registered N:1 wide mux with combinational LO and faultable O
// Revision : 1.0
// ============================================================================
`default_nettype none

module muxf_tree_fi
  import muxf_pkg::*;
#(
  parameter int               WIDTH  = 1,
  parameter int               NUM_IN = 8,
  parameter logic [WIDTH-1:0] INIT   = '0,
  parameter int               CNT_W  = 16
) (
  input  logic                      C,
  input  logic                      R,
  input  logic                      CE,
  input  logic [NUM_IN*WIDTH-1:0]   I,
  input  logic [$clog2(NUM_IN)-1:0] S,
  output logic [WIDTH-1:0]          LO,
  output logic [WIDTH-1:0]          O,
  input  logic                      fi_valid,
  output logic                      fi_ready,
  input  logic [1:0]                fi_mode,
  input  logic [WIDTH-1:0]          fi_mask,
  input  logic [WIDTH-1:0]          fi_value,
  input  logic [CNT_W-1:0]          fi_cycles,
  output logic                      fi_active
);

  logic [WIDTH-1:0] slot [NUM_IN];
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] o_d;
  logic [WIDTH-1:0] o_q;
  fi_mode_t         app_mode;
  logic [WIDTH-1:0] app_mask;
  logic [WIDTH-1:0] app_value;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_slot
    assign slot[k] = I[k*WIDTH +: WIDTH];
  end

  assign m  = slot[S];
  assign LO = m;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    assign o_d[b] = fault_apply(m[b], app_mask[b], app_value[b], app_mode);
  end

  muxf_fi_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk_i       (C),
    .rst_i       (R),
    .ce_i        (CE),
    .fi_valid_i  (fi_valid),
    .fi_ready_o  (fi_ready),
    .fi_mode_i   (fi_mode_t'(fi_mode)),
    .fi_mask_i   (fi_mask),
    .fi_value_i  (fi_value),
    .fi_cycles_i (fi_cycles),
    .fi_active_o (fi_active),
    .app_mode_o  (app_mode),
    .app_mask_o  (app_mask),
    .app_value_o (app_value)
  );

  always_ff @(posedge C) begin
    if (R) begin
      o_q <= INIT;
    end else if (CE) begin
      o_q <= o_d;
    end
  end

  assign O = o_q;

endmodule

`default_nettype wire

// File: tb/tb_muxf_tree_fi.sv
// ============================================================================
// tb_muxf_tree_fi : directed vector table plus randomized run against a model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muxf_tree_fi;

  localparam logic [3:0]  INIT_V = 4'hA;
  localparam logic [31:0] SEL    = 32'h76543210;
  localparam logic [31:0] ALLF   = 32'hFFFFFFFF;
  localparam logic [31:0] ALL3   = 32'h33333333;

  logic        C = 1'b0;
  logic        R, CE;
  logic [31:0] I;
  logic [2:0]  S;
  logic        fi_valid;
  logic [1:0]  fi_mode;
  logic [3:0]  fi_mask, fi_value;
  logic [15:0] fi_cycles;
  wire  [3:0]  LO, O;
  wire         fi_ready, fi_active;

  int n_vec = 0;
  int n_cmp = 0;
  int n_mis = 0;

  // Model: remaining faulted captures plus a sticky flag
  logic [3:0] md_o;
  int         md_rem;
  bit         md_sticky;
  logic [1:0] md_kind;
  logic [3:0] md_mask, md_val;

  typedef struct {
    logic        r, ce;
    logic [31:0] i;
    logic [2:0]  s;
    logic        v;
    logic [1:0]  mode;
    logic [3:0]  mask, val;
    logic [15:0] cyc;
    logic [3:0]  e_lo, e_o;
    logic        e_act, e_rdy;
  } vec_t;

  vec_t vt[$];

  muxf_tree_fi #(
    .WIDTH(4), .NUM_IN(8), .INIT(INIT_V), .CNT_W(16)
  ) dut (
    .C(C), .R(R), .CE(CE), .I(I), .S(S), .LO(LO), .O(O),
    .fi_valid(fi_valid), .fi_ready(fi_ready), .fi_mode(fi_mode),
    .fi_mask(fi_mask), .fi_value(fi_value), .fi_cycles(fi_cycles),
    .fi_active(fi_active)
  );

  always #5 C = ~C;

  function automatic vec_t mk(logic r, logic ce, logic [31:0] i, logic [2:0] s,
                              logic v, logic [1:0] mode, logic [3:0] mask,
                              logic [3:0] val, logic [15:0] cyc, logic [3:0] elo,
                              logic [3:0] eo, logic eact, logic erdy);
    vec_t x;
    x.r = r; x.ce = ce; x.i = i; x.s = s; x.v = v; x.mode = mode;
    x.mask = mask; x.val = val; x.cyc = cyc;
    x.e_lo = elo; x.e_o = eo; x.e_act = eact; x.e_rdy = erdy;
    return x;
  endfunction

  function automatic logic [3:0] slot_of(logic [31:0] iv, logic [2:0] sv);
    logic [31:0] t;
    t = iv >> (4 * int'(sv));
    return t[3:0];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [3:0] m;
    bit act, rdy;
    if (R) begin
      md_o = INIT_V; md_rem = 0; md_sticky = 0;
      md_kind = 2'b00; md_mask = '0; md_val = '0;
    end else begin
      m   = slot_of(I, S);
      act = (md_rem > 0) || md_sticky;
      rdy = (md_rem == 0);
      if (CE) begin
        if (!act)              md_o = m;
        else if (md_kind == 1) md_o = (m & ~md_mask) | (md_val & md_mask);
        else                   md_o = m ^ md_mask;
        if (md_rem > 0) md_rem--;
      end
      if (fi_valid && rdy) begin
        if (fi_mode == 2'b01 || fi_mode == 2'b10) begin
          md_kind = fi_mode; md_mask = fi_mask; md_val = fi_value;
          md_rem = int'(fi_cycles); md_sticky = (fi_cycles == 0);
        end else begin
          md_sticky = 0;
        end
      end
    end
  endtask

  task automatic drive(input vec_t x);
    R = x.r; CE = x.ce; I = x.i; S = x.s; fi_valid = x.v; fi_mode = x.mode;
    fi_mask = x.mask; fi_value = x.val; fi_cycles = x.cyc;
  endtask

  initial begin
    vec_t x;
    // reset (command offered alongside R must be dropped)
    vt.push_back(mk(1,1,SEL ,5,1,2'b01,4'hF,4'h0,0, 4'h5,INIT_V,0,1));
    vt.push_back(mk(1,0,SEL ,2,0,2'b00,4'h0,4'h0,0, 4'h2,INIT_V,0,1));
    for (int k = 0; k < 8; k++)
      vt.push_back(mk(0,1,SEL,3'(k),0,2'b00,4'h0,4'h0,0, 4'(k),4'(k),0,1));
    vt.push_back(mk(0,0,SEL ,3,0,2'b00,4'h0,4'h0,0, 4'h3,4'h7,0,1));
    vt.push_back(mk(0,0,SEL ,3,0,2'b00,4'h0,4'h0,0, 4'h3,4'h7,0,1));
    // timed force, 3 captures, CE gap mid-window, command ignored while busy
    vt.push_back(mk(0,1,ALLF,0,1,2'b01,4'h3,4'h1,3, 4'hF,4'hF,1,0));
    vt.push_back(mk(0,1,ALLF,0,1,2'b10,4'hF,4'h0,0, 4'hF,4'hD,1,0));
    vt.push_back(mk(0,0,ALLF,0,0,2'b00,4'h0,4'h0,0, 4'hF,4'hD,1,0));
    vt.push_back(mk(0,1,ALLF,0,0,2'b00,4'h0,4'h0,0, 4'hF,4'hD,1,0));
    vt.push_back(mk(0,1,ALLF,0,0,2'b00,4'h0,4'h0,0, 4'hF,4'hD,0,1));
    vt.push_back(mk(0,1,ALLF,0,1,2'b00,4'h0,4'h0,0, 4'hF,4'hF,0,1));
    // sticky flip, then clear
    vt.push_back(mk(0,1,ALL3,1,1,2'b10,4'h8,4'h0,0, 4'h3,4'h3,1,1));
    vt.push_back(mk(0,1,ALL3,1,0,2'b00,4'h0,4'h0,0, 4'h3,4'hB,1,1));
    vt.push_back(mk(0,1,ALL3,1,0,2'b00,4'h0,4'h0,0, 4'h3,4'hB,1,1));
    vt.push_back(mk(0,1,ALL3,1,1,2'b00,4'h0,4'h0,0, 4'h3,4'hB,0,1));
    vt.push_back(mk(0,1,ALL3,1,0,2'b00,4'h0,4'h0,0, 4'h3,4'h3,0,1));
    // reserved mode acts as clear
    vt.push_back(mk(0,1,ALL3,1,1,2'b10,4'h8,4'h0,0, 4'h3,4'h3,1,1));
    vt.push_back(mk(0,1,ALL3,1,1,2'b11,4'h0,4'h0,0, 4'h3,4'hB,0,1));
    vt.push_back(mk(0,1,ALL3,1,0,2'b00,4'h0,4'h0,0, 4'h3,4'h3,0,1));
    // reset in the middle of a long timed window
    vt.push_back(mk(0,1,ALL3,2,1,2'b01,4'hF,4'h5,10,4'h3,4'h3,1,0));
    vt.push_back(mk(0,1,ALL3,2,0,2'b00,4'h0,4'h0,0, 4'h3,4'h5,1,0));
    vt.push_back(mk(0,1,ALL3,2,0,2'b00,4'h0,4'h0,0, 4'h3,4'h5,1,0));
    vt.push_back(mk(1,1,ALL3,2,0,2'b00,4'h0,4'h0,0, 4'h3,INIT_V,0,1));
    vt.push_back(mk(0,1,ALL3,2,0,2'b00,4'h0,4'h0,0, 4'h3,4'h3,0,1));
    // sticky force replaced by a 2-cycle flip
    vt.push_back(mk(0,1,SEL ,6,1,2'b01,4'hF,4'h0,0, 4'h6,4'h6,1,1));
    vt.push_back(mk(0,1,SEL ,6,1,2'b10,4'h1,4'h0,2, 4'h6,4'h0,1,0));
    vt.push_back(mk(0,1,SEL ,6,0,2'b00,4'h0,4'h0,0, 4'h6,4'h7,1,0));
    vt.push_back(mk(0,1,SEL ,6,0,2'b00,4'h0,4'h0,0, 4'h6,4'h7,0,1));
    vt.push_back(mk(0,1,SEL ,6,0,2'b00,4'h0,4'h0,0, 4'h6,4'h6,0,1));

    md_o = 'x; md_rem = 0; md_sticky = 0; md_kind = 0; md_mask = 0; md_val = 0;

    foreach (vt[n]) begin
      x = vt[n];
      drive(x);
      #1;
      chk($sformatf("tab%0d_LO", n), 16'(LO), 16'(x.e_lo));
      model_edge();
      @(posedge C);
      #1;
      n_vec++;
      chk($sformatf("tab%0d_O", n),      16'(O),         16'(x.e_o));
      chk($sformatf("tab%0d_active", n), 16'(fi_active), 16'(x.e_act));
      chk($sformatf("tab%0d_ready", n),  16'(fi_ready),  16'(x.e_rdy));
    end

    for (int n = 0; n < 500; n++) begin
      R         = ($urandom_range(0, 24) == 0);
      CE        = ($urandom_range(0, 3) != 0);
      I         = $urandom;
      S         = 3'($urandom_range(0, 7));
      fi_valid  = ($urandom_range(0, 2) == 0);
      fi_mode   = 2'($urandom_range(0, 3));
      fi_mask   = 4'($urandom);
      fi_value  = 4'($urandom);
      fi_cycles = 16'($urandom_range(0, 4));
      #1;
      chk("rnd_LO", 16'(LO), 16'(slot_of(I, S)));
      model_edge();
      @(posedge C);
      #1;
      n_vec++;
      chk("rnd_O",      16'(O),         16'(md_o));
      chk("rnd_active", 16'(fi_active), 16'((md_rem > 0) || md_sticky));
      chk("rnd_ready",  16'(fi_ready),  16'(md_rem == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
